divider_128b_seq: RTL and testbench

- Iterative restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit divisor, producing a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- It is the inverse arithmetic path to the registered 64b multiplier. A 128b product fed back with one operand recovers the other operand with zero remainder.
- It sits beside the multiplier in the arithmetic module set and computes one quotient bit per enabled cycle.

---
 rtl/divider_128b_seq.sv | 101 ++++++++++
 tb/tb_divider_128b_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_128b_seq.sv
// divider_128b_seq: iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per enabled cycle.
module divider_128b_seq #(
    parameter int WIDTH = 64
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic                 iClr,
    input  logic                 iStart,
    input  logic [2*WIDTH-1:0]   iDividend,
    input  logic [WIDTH-1:0]     iDivisor,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oDivZero,
    output logic [2*WIDTH-1:0]   oQuotient,
    output logic [WIDTH-1:0]     oRemainder
);
    localparam int CW = $clog2(2*WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, ZDIV} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] dvd_q, dvd_d, quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d, acc_q, acc_d, rem_q, rem_d, diff;
    logic [WIDTH:0]     r;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d, dz_q, dz_d, ge;
    // The dividend register doubles as the quotient: each shift drops a dividend
    // bit off the top and brings a quotient bit in at the bottom.
    always_comb begin
        r       = {acc_q, dvd_q[2*WIDTH-1]};
        ge      = r >= {1'b0, dvs_q};
        diff    = r[WIDTH-1:0] - dvs_q;
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        if (iEn) begin
            case (state_q)
                IDLE: if (iStart) begin
                    dvd_d   = iDividend;
                    dvs_d   = iDivisor;
                    acc_d   = '0;
                    cnt_d   = CW'(2*WIDTH-1);
                    dz_d    = 1'b0;
                    state_d = (iDivisor == '0) ? ZDIV : RUN;
                end
                RUN: begin
                    acc_d = ge ? diff : r[WIDTH-1:0];
                    dvd_d = {dvd_q[2*WIDTH-2:0], ge};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quo_d   = {dvd_q[2*WIDTH-2:0], ge};
                        rem_d   = acc_d;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                ZDIV: begin
                    quo_d   = '1;
                    rem_d   = dvd_q[WIDTH-1:0];
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end
    assign oBusy      = state_q != IDLE;
    assign oDone      = done_q;
    assign oDivZero   = dz_q;
    assign oQuotient  = quo_q;
    assign oRemainder = rem_q;
endmodule

// File: tb/tb_divider_128b_seq.sv
// tb_divider_128b_seq: randomized and directed divisions scored against plain 128-bit arithmetic.
module tb_divider_128b_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         clr = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] dividend = '0;
    logic [63:0]  divisor = '0;
    logic         busy, done, dz;
    logic [127:0] quo;
    logic [63:0]  rem;
    int           cyc = 0;
    int           total = 0;
    int           passed = 0;

    typedef struct {
        logic [127:0] a;
        logic [63:0]  b;
        logic [127:0] q;
        logic [63:0]  r;
        logic         z;
        int           at;
    } exp_t;
    exp_t sb[$];

    divider_128b_seq #(.WIDTH(64)) dut (
        .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr), .iStart(start_i),
        .iDividend(dividend), .iDivisor(divisor), .oBusy(busy), .oDone(done),
        .oDivZero(dz), .oQuotient(quo), .oRemainder(rem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    // Monitor: every oDone must match the oldest outstanding division.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                logic [191:0] recon;
                e = sb.pop_front();
                chk("quotient", quo, e.q);
                chk("remainder", rem, e.r);
                chk("divzero", dz, e.z);
                chk("done_cycle", cyc, e.at);
                chk("busy_at_done", busy, 0);
                if (e.b != 0) begin
                    recon = {64'b0, quo} * {128'b0, e.b} + {128'b0, rem};
                    chk("invariant", recon, {64'b0, e.a});
                    chk("rem_lt_div", rem < e.b, 1);
                end
            end
        end
    end

    // Call just after a negedge with the DUT idle and iEn high.
    task automatic start(input logic [127:0] a, input logic [63:0] b, input int lat);
        exp_t e;
        start_i = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        e.a = a;
        e.b = b;
        e.q = (b == 0) ? '1 : a / {64'b0, b};
        e.r = (b == 0) ? a[63:0] : 64'(a % {64'b0, b});
        e.z = (b == 0);
        e.at = cyc + lat;
        sb.push_back(e);
        chk("busy_after_start", busy, 1);
        start_i = 1'b0;
        dividend = {$urandom, $urandom, $urandom, $urandom};
        divisor = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_outputs"}, {busy, done, dz, quo, rem}, '0);
    endtask

    // Abort at a given iteration with either reset or clear.
    task automatic abort_at(input int iter, input bit use_clr);
        @(negedge clk);
        start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom} | 64'h1, 128);
        repeat (iter) @(posedge clk);
        @(negedge clk);
        if (use_clr) clr = 1'b1; else rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        clr = 1'b0;
        rst = 1'b0;
        chk_zero(use_clr ? "clr" : "rst");
        repeat (200) @(posedge clk);
        #1;
        chk_zero(use_clr ? "clr_later" : "rst_later");
    endtask

    initial begin
        logic [63:0]  a;
        logic [127:0] x;
        logic [63:0]  y;
        int           k;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        a = 64'hAAAB55D4A952954B;
        @(negedge clk);
        start({64'b0, a} * {64'b0, a}, a, 128);
        wait_idle();

        @(negedge clk);
        start(128'd100, 64'd7, 128);
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        start(128'd1, 64'hFFFFFFFFFFFFFFFF, 128);
        wait_idle();

        @(negedge clk);
        start('1, 64'd1, 128);
        wait_idle();
        @(negedge clk);
        start(128'd1 << 127, 64'h8000000000000000, 128);
        wait_idle();

        @(negedge clk);
        start(128'd12345, 64'd0, 1);
        wait_idle();
        @(posedge clk);
        #1;
        chk("busy_after_zdiv", busy, 0);

        @(negedge clk);
        start(128'd100, 64'd7, 138);
        repeat (20) @(negedge clk);
        start_i = 1'b1;
        dividend = 128'd999;
        divisor = 64'd3;
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle();

        abort_at(50, 1'b0);
        abort_at(80, 1'b1);
        @(negedge clk);
        start(128'd100, 64'd7, 128);
        wait_idle();

        for (int n = 0; n < 20; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) y = 0;
            k = (y == 0) ? 0 : $urandom_range(0, 3);
            @(negedge clk);
            start(x, y, (y == 0) ? 1 : 128 + k);
            if (k > 0) begin
                repeat (5) @(negedge clk);
                en = 1'b0;
                repeat (k) @(negedge clk);
                en = 1'b1;
            end
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1);
    end
endmodule
